// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a 16 x 8-bit register file.
// An external I2C controller reads and writes the registers over SDA/SCL.
// A local synchronous port reads and writes the same registers.
// The target never stretches the clock, so SCL is never driven.
module i2c_target_regs #(
    parameter logic [6:0]  ADDR = 7'h42,
    parameter int unsigned FILT = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       sda_read,
    output logic       sda_write,
    input  logic       scl_read,
    output logic       scl_write,
    input  logic [3:0] loc_addr,
    input  logic       loc_we,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    output logic       wr_strobe,
    output logic [3:0] wr_idx,
    output logic       busy
);

    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_READ_ACK
    } state_t;

    // Bit 1 is SCL and bit 0 is SDA throughout the input path.
    logic [1:0] pad_in;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] filt;

    logic       sda_s, scl_s;
    logic       sda_q, scl_q;
    logic       scl_rise, scl_fall, start_det, stop_det;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [3:0] ptr;
    logic       rw;
    // In the ACK states, phase is set once the ACK or release has been applied.
    // In READ, phase is set while a register load is still pending for the next SCL fall.
    logic       phase;

    logic [7:0] regs [16];
    logic [7:0] ptr_data;
    logic [7:0] rx_byte;
    logic       commit;

    assign pad_in    = {scl_read, sda_read};
    assign scl_write = 1'b1;

    // Two-flop synchronizer. The bus idles high, so both stages reset to 1.
    always_ff @(posedge CLK) begin
        // NOTE: clocked state always uses non-blocking assignments.
        // Every flop then samples the pre-edge values, whatever order the blocks run in.
        if (reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= pad_in;
            sync2 <= sync1;
        end
    end

    generate
        if (FILT == 0) begin : g_nofilt
            assign filt = sync2;
        end else begin : g_filt
            for (genvar i = 0; i < 2; i++) begin : g_line
                logic [CW-1:0] cnt;
                logic          filt_q;

                assign filt[i] = filt_q;

                // Accept a new level only after it has persisted for FILT further cycles.
                always_ff @(posedge CLK) begin
                    if (reset) begin
                        filt_q <= 1'b1;
                        cnt    <= '0;
                    end else if (sync2[i] == filt_q) begin
                        cnt <= '0;
                    end else if (cnt == CW'(FILT - 1)) begin
                        filt_q <= sync2[i];
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end
    endgenerate

    assign sda_s = filt[0];
    assign scl_s = filt[1];

    // Delay the filtered lines by one cycle for edge detection.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sda_q <= 1'b1;
            scl_q <= 1'b1;
        end else begin
            sda_q <= sda_s;
            scl_q <= scl_s;
        end
    end

    assign scl_rise  =  scl_s & ~scl_q;
    assign scl_fall  = ~scl_s &  scl_q;
    assign start_det =  scl_s &  scl_q &  sda_q & ~sda_s;
    assign stop_det  =  scl_s &  scl_q & ~sda_q &  sda_s;

    assign rx_byte  = {shreg[6:0], sda_s};
    assign ptr_data = regs[ptr];
    // A write byte commits on its 8th SCL rise.
    // START and STOP cannot coincide with a rise, so an abort never commits.
    assign commit   = (state == S_WRITE) && scl_rise && (bit_cnt == 3'd7);

    // Protocol engine. START and STOP override every state.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            phase     <= 1'b0;
            sda_write <= 1'b1;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_idx    <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_det) begin
                state     <= S_ADDR;
                bit_cnt   <= '0;
                phase     <= 1'b0;
                sda_write <= 1'b1;
            end else if (stop_det) begin
                state     <= S_IDLE;
                phase     <= 1'b0;
                sda_write <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: ;

                    S_ADDR: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            phase <= 1'b0;
                            if (shreg[6:0] == ADDR) begin
                                busy  <= 1'b1;
                                rw    <= sda_s;
                                state <= S_ADDR_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end

                    S_ADDR_ACK: if (scl_fall) begin
                        if (!phase) begin
                            sda_write <= 1'b0;
                            phase     <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (rw) begin
                                // The first read bit goes out on the same fall that ends the ACK.
                                sda_write <= ptr_data[7];
                                shreg     <= {ptr_data[6:0], 1'b0};
                                state     <= S_READ;
                            end else begin
                                sda_write <= 1'b1;
                                state     <= S_PTR;
                            end
                        end
                    end

                    S_PTR: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ptr   <= rx_byte[3:0];
                            phase <= 1'b0;
                            state <= S_PTR_ACK;
                        end
                    end

                    S_PTR_ACK, S_WRITE_ACK: if (scl_fall) begin
                        if (!phase) begin
                            sda_write <= 1'b0;
                            phase     <= 1'b1;
                        end else begin
                            sda_write <= 1'b1;
                            phase     <= 1'b0;
                            state     <= S_WRITE;
                        end
                    end

                    S_WRITE: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            wr_strobe <= 1'b1;
                            wr_idx    <= ptr;
                            ptr       <= ptr + 4'd1;
                            phase     <= 1'b0;
                            state     <= S_WRITE_ACK;
                        end
                    end

                    S_READ: begin
                        if (scl_fall) begin
                            if (phase) begin
                                sda_write <= ptr_data[7];
                                shreg     <= {ptr_data[6:0], 1'b0};
                                phase     <= 1'b0;
                            end else begin
                                sda_write <= shreg[7];
                                shreg     <= {shreg[6:0], 1'b0};
                            end
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ptr   <= ptr + 4'd1;
                                phase <= 1'b0;
                                state <= S_READ_ACK;
                            end
                        end
                    end

                    S_READ_ACK: begin
                        if (scl_fall && !phase) begin
                            sda_write <= 1'b1;
                            phase     <= 1'b1;
                        end else if (scl_rise && phase) begin
                            if (sda_s) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                // Defer the register load to the next SCL fall.
                                state <= S_READ;
                            end
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Register file. The local write comes first, so a same-index I2C commit overrides it.
    always_ff @(posedge CLK) begin
        // NOTE: this array is reset on purpose; the register file has defined
        // contents after reset. A plain RAM would normally not be reset.
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            if (loc_we) regs[loc_addr] <= loc_wdata;
            if (commit) regs[ptr]      <= rx_byte;
        end
    end

    // Registered local read port with one cycle of latency.
    always_ff @(posedge CLK) begin
        if (reset) loc_rdata <= '0;
        else       loc_rdata <= regs[loc_addr];
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed bench for i2c_target_regs.
// The bench acts as the I2C bus master on a wired-AND open-drain bus.
module tb_i2c_target_regs;

    localparam int Q = 10;  // CLK cycles per quarter SCL period

    logic       CLK = 1'b0;
    logic       reset;
    logic       sda_read, sda_write, scl_read, scl_write;
    logic [3:0] loc_addr;
    logic       loc_we;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [3:0] wr_idx;
    logic       busy;

    logic m_sda = 1'b1;
    logic m_scl = 1'b1;

    assign sda_read = m_sda & sda_write;
    assign scl_read = m_scl & scl_write;

    always #5 CLK = ~CLK;

    i2c_target_regs dut (
        .CLK       (CLK),
        .reset     (reset),
        .sda_read  (sda_read),
        .sda_write (sda_write),
        .scl_read  (scl_read),
        .scl_write (scl_write),
        .loc_addr  (loc_addr),
        .loc_we    (loc_we),
        .loc_wdata (loc_wdata),
        .loc_rdata (loc_rdata),
        .wr_strobe (wr_strobe),
        .wr_idx    (wr_idx),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] strobe_idx [$];
    int         sda_low_cnt = 0;
    int         busy_cnt    = 0;

    always @(negedge CLK) begin
        if (wr_strobe === 1'b1) strobe_idx.push_back(wr_idx);
        if (sda_write === 1'b0) sda_low_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        m_sda = b;    tick(Q);
        m_scl = 1'b1; tick(Q);
        s = sda_read; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(mack, s);
    endtask

    // Data byte whose commit cycle coincides with a local write.
    // The pad SCL rise lands at N0. The commit edge is the (3+FILT)-th rising edge after it.
    task automatic write_byte_coll(input logic [7:0] d, input logic [3:0] la,
                                   input logic [7:0] lw, output logic ack);
        logic s;
        for (int i = 7; i >= 1; i--) bit_cycle(d[i], s);
        m_sda = d[0]; tick(Q);
        m_scl = 1'b1;
        tick(4);
        check("coll_strobe_early", wr_strobe, 1'b0);
        loc_addr = la; loc_wdata = lw; loc_we = 1'b1;
        tick(1);
        loc_we = 1'b0;
        check("coll_strobe_timing", wr_strobe, 1'b1);
        tick(2 * Q - 5);
        m_scl = 1'b0; tick(Q);
        bit_cycle(1'b1, ack);
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
        loc_addr = a; loc_wdata = d; loc_we = 1'b1;
        tick(1);
        loc_we = 1'b0;
    endtask

    task automatic loc_read(input logic [3:0] a, output logic [7:0] d);
        loc_addr = a; loc_we = 1'b0;
        tick(1);
        d = loc_rdata;
    endtask

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } loc_vec_t;

    loc_vec_t vt [7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       a;
        logic       s;
        logic [7:0] d;
        int         sb, lb, bb;

        // A write cycle reads back the old value because the read is registered.
        vt[0] = '{1'b1, 4'h1, 8'h10, 8'h00};
        vt[1] = '{1'b0, 4'h1, 8'h00, 8'h10};
        vt[2] = '{1'b1, 4'hF, 8'hFF, 8'h00};
        vt[3] = '{1'b0, 4'hF, 8'h00, 8'hFF};
        vt[4] = '{1'b1, 4'h1, 8'h20, 8'h10};
        vt[5] = '{1'b0, 4'h1, 8'h00, 8'h20};
        vt[6] = '{1'b0, 4'h0, 8'h00, 8'h00};

        reset = 1'b1; loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
        tick(3);
        check("rst_sda_write", sda_write, 1'b1);
        check("rst_scl_write", scl_write, 1'b1);
        check("rst_loc_rdata", loc_rdata, 8'h00);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_idx",    wr_idx,    4'h0);
        check("rst_busy",      busy,      1'b0);
        reset = 1'b0;
        tick(5);

        // Local port vectors
        for (int i = 0; i < 7; i++) begin
            loc_we = vt[i].we; loc_addr = vt[i].addr; loc_wdata = vt[i].wdata;
            tick(1);
            loc_we = 1'b0;
            check($sformatf("loc_vec%0d", i), loc_rdata, vt[i].exp_rdata);
        end

        // Write: pointer 3, then two data bytes
        sb = strobe_idx.size();
        i2c_start;
        write_byte(8'h84, a); check("wr_addr_ack", a, 1'b0);
        check("wr_busy", busy, 1'b1);
        write_byte(8'h03, a); check("wr_ptr_ack", a, 1'b0);
        write_byte(8'hA5, a); check("wr_d0_ack", a, 1'b0);
        write_byte(8'h5A, a); check("wr_d1_ack", a, 1'b0);
        i2c_stop;
        tick(5);
        check("wr_busy_after_stop", busy, 1'b0);
        check("wr_strobe_count", strobe_idx.size() - sb, 2);
        check("wr_idx0", strobe_idx[sb],     4'h3);
        check("wr_idx1", strobe_idx[sb + 1], 4'h4);
        loc_read(4'h3, d); check("wr_reg3", d, 8'hA5);
        loc_read(4'h4, d); check("wr_reg4", d, 8'h5A);

        // Wrap read through a repeated START
        loc_write(4'hF, 8'h11);
        loc_write(4'h0, 8'h22);
        i2c_start;
        write_byte(8'h84, a); check("wrap_addr_ack", a, 1'b0);
        write_byte(8'h0F, a); check("wrap_ptr_ack", a, 1'b0);
        i2c_start;
        write_byte(8'h85, a); check("wrap_raddr_ack", a, 1'b0);
        read_byte(1'b0, d); check("wrap_byte0", d, 8'h11);
        read_byte(1'b1, d); check("wrap_byte1", d, 8'h22);
        tick(2);
        check("wrap_sda_released", sda_write, 1'b1);
        check("wrap_busy_nack", busy, 1'b0);
        i2c_stop;
        tick(5);

        // Address mismatch
        sb = strobe_idx.size(); lb = sda_low_cnt; bb = busy_cnt;
        i2c_start;
        write_byte(8'h86, a); check("mm_addr_nack", a, 1'b1);
        write_byte(8'h00, a); check("mm_data_nack", a, 1'b1);
        i2c_stop;
        tick(5);
        check("mm_sda_never_low", sda_low_cnt - lb, 0);
        check("mm_busy_never", busy_cnt - bb, 0);
        check("mm_no_strobe", strobe_idx.size() - sb, 0);

        // STOP in the middle of a data byte
        loc_write(4'h2, 8'h3C);
        sb = strobe_idx.size();
        i2c_start;
        write_byte(8'h84, a);
        write_byte(8'h02, a);
        for (int i = 0; i < 4; i++) bit_cycle(1'b1, s);
        i2c_stop;
        tick(5);
        check("abort_no_strobe", strobe_idx.size() - sb, 0);
        check("abort_busy", busy, 1'b0);
        check("abort_sda", sda_write, 1'b1);
        loc_read(4'h2, d); check("abort_reg2", d, 8'h3C);

        // Reset asserted during the address ACK
        loc_addr = 4'h3; tick(1);
        i2c_start;
        for (int i = 7; i >= 0; i--) begin
            d = 8'h84;
            bit_cycle(d[i], s);
        end
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        check("mid_ack_driven", sda_write, 1'b0);
        reset = 1'b1;
        tick(1);
        check("mid_rst_sda", sda_write, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_strobe", wr_strobe, 1'b0);
        check("mid_rst_wr_idx", wr_idx, 4'h0);
        check("mid_rst_rdata", loc_rdata, 8'h00);
        reset = 1'b0;
        tick(5);
        loc_read(4'h3, d); check("regfile_reset", d, 8'h00);

        // Collision: same index, then a different index
        i2c_start;
        write_byte(8'h84, a);
        write_byte(8'h05, a);
        write_byte_coll(8'h77, 4'h5, 8'h33, a); check("coll_ack", a, 1'b0);
        i2c_stop;
        tick(5);
        loc_read(4'h5, d); check("coll_same_idx", d, 8'h77);
        i2c_start;
        write_byte(8'h84, a);
        write_byte(8'h05, a);
        write_byte_coll(8'h78, 4'h6, 8'h66, a);
        i2c_stop;
        tick(5);
        loc_read(4'h5, d); check("coll_i2c_idx5", d, 8'h78);
        loc_read(4'h6, d); check("coll_local_idx6", d, 8'h66);

        // Pointer persists across transactions
        loc_write(4'h7, 8'h9E);
        loc_write(4'h8, 8'hC7);
        i2c_start;
        write_byte(8'h84, a);
        write_byte(8'h07, a);
        i2c_stop;
        i2c_start;
        write_byte(8'h85, a); check("ptr_raddr_ack", a, 1'b0);
        read_byte(1'b1, d); check("ptr_read7", d, 8'h9E);
        i2c_stop;
        i2c_start;
        write_byte(8'h85, a);
        read_byte(1'b1, d); check("ptr_read8", d, 8'hC7);
        i2c_stop;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
